// File: rtl/escalonador_pkg.sv
// Shared types and helpers for the round-robin display scheduler.
package escalonador_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    EXIBINDO = 1'b1
  } estado_t;

  // Largest value the two-digit decoder can show without wrapping.
  localparam logic [31:0] VALOR_MAX = 32'd99;

  // Clamp a zero-extended value to 99, so an oversized value reads "99"
  // instead of showing a misleading tens digit.
  function automatic logic [31:0] sat99(input logic [31:0] v);
    return (v > VALOR_MAX) ? VALOR_MAX : v;
  endfunction

endpackage

// File: rtl/escalonador_display_arbitro_rr.sv
// Combinational round-robin pick: search ultimo+1, ultimo+2, ... ultimo
// (mod N_REQ), so the previous winner is considered last.
module arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ultimo,
  output logic [IDW-1:0]   vencedor,
  output logic             achou
);

  // First requester found in rotated order wins.
  always_comb begin
    achou    = 1'b0;
    vencedor = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(ultimo) + k) % N_REQ;
      if (!achou && req[idx]) begin
        achou    = 1'b1;
        vencedor = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/escalonador_display.sv
// Time-shares the two-digit display among N_REQ requesters, each winner
// holding it for DWELL cycles. All outputs are registered.
module escalonador_display
  import escalonador_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DWELL      = 50_000_000,
  parameter int LARG_VALOR = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req,
  input  logic [N_REQ*LARG_VALOR-1:0]               valores,
  output logic [N_REQ-1:0]                          gnt,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] id_ativo,
  output logic                                      ativo,
  output logic [31:0]                               valor_display
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_RECARGA = CW'(DWELL - 1);

  estado_t        estado, estado_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [IDW-1:0] ultimo, ultimo_next;
  logic [IDW-1:0] id_next;
  logic [IDW-1:0] vencedor;
  logic           achou;
  logic           libera;
  logic [N_REQ-1:0] gnt_next;
  logic [31:0]    valor_next;

  arbitro_rr #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arbitro (
    .req      (req),
    .ultimo   (ultimo),
    .vencedor (vencedor),
    .achou    (achou)
  );

  // Next-state logic: arbitrate when idle or on release (expiry or the
  // holder dropping its request); otherwise keep counting down.
  always_comb begin
    estado_next = estado;
    cnt_next    = cnt;
    ultimo_next = ultimo;
    id_next     = id_ativo;
    gnt_next    = '0;
    valor_next  = '0;
    libera      = (estado == EXIBINDO) && ((cnt == '0) || !req[id_ativo]);

    if ((estado == OCIOSO) || libera) begin
      if (achou) begin
        estado_next = EXIBINDO;
        cnt_next    = CNT_RECARGA;
        ultimo_next = vencedor;
        id_next     = vencedor;
      end else begin
        estado_next = OCIOSO;
        cnt_next    = '0;
        id_next     = '0;
      end
    end else begin
      cnt_next = cnt - CW'(1);
    end

    // Value follows the holder every cycle, so live changes show up.
    if (estado_next == EXIBINDO) begin
      gnt_next   = N_REQ'(1) << id_next;
      valor_next = sat99(32'(valores[int'(id_next)*LARG_VALOR +: LARG_VALOR]));
    end
  end

  // State, counter, pointer and output registers; reset makes requester 0
  // the first winner by parking the pointer on the last index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= OCIOSO;
      cnt           <= '0;
      ultimo        <= IDW'(N_REQ - 1);
      id_ativo      <= '0;
      gnt           <= '0;
      valor_display <= '0;
    end else begin
      estado        <= estado_next;
      cnt           <= cnt_next;
      ultimo        <= ultimo_next;
      id_ativo      <= id_next;
      gnt           <= gnt_next;
      valor_display <= valor_next;
    end
  end

  assign ativo = (estado == EXIBINDO);

endmodule

// File: tb/tb_escalonador_display.sv
// Directed scoreboard bench for escalonador_display (N_REQ=4, DWELL=4).
module tb_escalonador_display;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] valores;
  logic [3:0]  gnt;
  logic [1:0]  id_ativo;
  logic        ativo;
  logic [31:0] valor_display;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] valor;
    string      nome;
  } esp_t;

  esp_t fila[$];
  int   testes = 0;
  int   falhas = 0;

  escalonador_display #(
    .N_REQ      (4),
    .DWELL      (4),
    .LARG_VALOR (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .valores       (valores),
    .gnt           (gnt),
    .id_ativo      (id_ativo),
    .ativo         (ativo),
    .valor_display (valor_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sample just after each falling clock edge, or just after
  // reset asserts, and check against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (fila.size() > 0) begin
        esp_t e;
        logic ok;
        e  = fila.pop_front();
        ok = 1'b1;
        testes += 4;
        if (gnt !== e.gnt) begin
          falhas++; ok = 1'b0;
          $display("[TB] FAIL %s gnt: got %b, want %b", e.nome, gnt, e.gnt);
        end
        if (id_ativo !== e.id) begin
          falhas++; ok = 1'b0;
          $display("[TB] FAIL %s id_ativo: got %0d, want %0d", e.nome, id_ativo, e.id);
        end
        if (ativo !== (e.gnt != 4'b0000)) begin
          falhas++; ok = 1'b0;
          $display("[TB] FAIL %s ativo: got %b, want %b", e.nome, ativo, (e.gnt != 4'b0000));
        end
        if (valor_display !== {24'd0, e.valor}) begin
          falhas++; ok = 1'b0;
          $display("[TB] FAIL %s valor_display: got %0d, want %0d", e.nome, valor_display, e.valor);
        end
        if (ok)
          $display("[TB] %s: gnt=%b id=%0d ativo=%b valor=%0d ok",
                   e.nome, gnt, id_ativo, ativo, valor_display);
      end
    end
  end

  // Drive inputs, take one clock edge, queue the outputs expected after it.
  task automatic step(input logic [3:0] r, input logic [31:0] v,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input logic [7:0] ev, input string nome);
    req     = r;
    valores = v;
    @(posedge clk);
    #1;
    fila.push_back('{eg, eid, ev, nome});
  endtask

  // Assert reset between clock edges (checks the asynchronous clear),
  // hold it over one edge, then release.
  task automatic do_reset(input string nome);
    @(negedge clk);
    #2;
    fila.push_back('{4'b0000, 2'd0, 8'd0, {nome, "_async"}});
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    fila.push_back('{4'b0000, 2'd0, 8'd0, {nome, "_hold"}});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    valores = 32'd0;
    @(posedge clk);
    #1;
    fila.push_back('{4'b0000, 2'd0, 8'd0, "reset_0"});
    @(posedge clk);
    #1;
    fila.push_back('{4'b0000, 2'd0, 8'd0, "reset_1"});
    rst_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 10; i++)
      step(4'b0000, 32'd0, 4'b0000, 2'd0, 8'd0, $sformatf("idle_%0d", i));

    // Lone requester 0: granted after one edge, held across reloads.
    for (int i = 0; i < 10; i++)
      step(4'b0001, 32'h0000_002A, 4'b0001, 2'd0, 8'd42, $sformatf("lone_%0d", i));
    step(4'b0000, 32'h0000_002A, 4'b0000, 2'd0, 8'd0, "lone_drop");
    step(4'b0001, 32'h0000_002A, 4'b0001, 2'd0, 8'd42, "lone_again");
    do_reset("rst_mid");

    // Rotation 0 -> 1 -> 3 -> 0 with req=1011, no idle gap.
    for (int i = 0; i < 4; i++)
      step(4'b1011, 32'h0D00_0B0A, 4'b0001, 2'd0, 8'd10, $sformatf("rr_r0_%0d", i));
    for (int i = 0; i < 4; i++)
      step(4'b1011, 32'h0D00_0B0A, 4'b0010, 2'd1, 8'd11, $sformatf("rr_r1_%0d", i));
    for (int i = 0; i < 4; i++)
      step(4'b1011, 32'h0D00_0B0A, 4'b1000, 2'd3, 8'd13, $sformatf("rr_r3_%0d", i));
    step(4'b1011, 32'h0D00_0B0A, 4'b0001, 2'd0, 8'd10, "rr_wrap");
    do_reset("rst_b");

    // Holder drops mid-dwell; new holder gets a full dwell; saturation.
    step(4'b0110, 32'h0016_1500, 4'b0010, 2'd1, 8'd21, "drop_c1");
    step(4'b0110, 32'h0016_1500, 4'b0010, 2'd1, 8'd21, "drop_c2");
    step(4'b0100, 32'h0016_1500, 4'b0100, 2'd2, 8'd22, "drop_hand");
    step(4'b0110, 32'h00FA_1500, 4'b0100, 2'd2, 8'd99, "sat_250");
    step(4'b0110, 32'h0007_1500, 4'b0100, 2'd2, 8'd7,  "val_7");
    step(4'b0110, 32'h0007_1500, 4'b0100, 2'd2, 8'd7,  "dwell_last");
    step(4'b0110, 32'h0007_1500, 4'b0010, 2'd1, 8'd21, "dwell_rot");
    do_reset("rst_c");

    // Late request waits for the current holder's expiry.
    step(4'b0001, 32'h0900_0005, 4'b0001, 2'd0, 8'd5, "nopre_0");
    step(4'b1001, 32'h0900_0005, 4'b0001, 2'd0, 8'd5, "nopre_1");
    step(4'b1001, 32'h0900_0005, 4'b0001, 2'd0, 8'd5, "nopre_2");
    step(4'b1001, 32'h0900_0005, 4'b0001, 2'd0, 8'd5, "nopre_3");
    step(4'b1001, 32'h0900_0005, 4'b1000, 2'd3, 8'd9, "nopre_hand");
    step(4'b1001, 32'h0900_0005, 4'b1000, 2'd3, 8'd9, "nopre_hold");

    // Bounded drain of the scoreboard.
    repeat (3) @(negedge clk);
    #2;
    if (fila.size() != 0) begin
      falhas++;
      $display("[TB] FAIL drain: got %0d pending, want 0", fila.size());
    end
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
